illegal_instruction_trap_sequencer: RTL and testbench

- Consumer side of the decode-stage illegal-instruction flag.
- On a flagged instruction: blocks issue, waits for all older in-flight instructions to drain, then raises a precise illegal-instruction exception request to the exception/CSR unit over a valid/ack handshake.
- Sits between decode/issue and the exception unit; holds captured PC, encoding and ID until the exception is accepted or the instruction is flushed.

---
 rtl/illegal_instruction_trap_sequencer.sv | 97 +++++++++
 tb/tb_illegal_instruction_trap_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/illegal_instruction_trap_sequencer.sv
// Holds a flagged illegal instruction at decode, waits for older instructions to drain,
// then raises a precise illegal-instruction exception request with a valid/ack handshake.
module illegal_instruction_trap_sequencer #(
  parameter int ID_W          = 3,
  parameter bit TVAL_ENCODING = 1'b1,
  parameter int COUNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               decode_valid,
  input  logic [31:0]        decode_pc,
  input  logic [31:0]        decode_instruction,
  input  logic [ID_W-1:0]    decode_id,
  input  logic               illegal_instruction,
  input  logic               gc_flush,
  input  logic               inflight_empty,
  output logic               issue_block,
  output logic               exception_valid,
  output logic [4:0]         exception_code,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_tval,
  output logic [ID_W-1:0]    exception_id,
  input  logic               exception_ack,
  output logic [COUNT_W-1:0] illegal_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    REQUEST = 2'd2
  } state_t;

  state_t state, next_state;

  logic [31:0]     cap_pc;
  logic [31:0]     cap_instruction;
  logic [ID_W-1:0] cap_id;
  logic            accept;
  logic            trap_taken;

  assign accept     = (state == IDLE) && decode_valid && illegal_instruction && !gc_flush;
  assign trap_taken = (state == REQUEST) && exception_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flush wins over drain completion; once requesting, only ack releases the request.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) next_state = DRAIN;
      end
      DRAIN: begin
        if (gc_flush)            next_state = IDLE;
        else if (inflight_empty) next_state = REQUEST;
      end
      REQUEST: begin
        if (exception_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pc          <= '0;
      cap_instruction <= '0;
      cap_id          <= '0;
    end else if (accept) begin
      cap_pc          <= decode_pc;
      cap_instruction <= decode_instruction;
      cap_id          <= decode_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (trap_taken && (illegal_count != {COUNT_W{1'b1}})) begin
      illegal_count <= illegal_count + COUNT_W'(1);
    end
  end

  assign issue_block     = (state != IDLE) || (decode_valid && illegal_instruction);
  assign exception_valid = (state == REQUEST);
  assign exception_code  = 5'd2;
  assign exception_pc    = cap_pc;
  assign exception_tval  = TVAL_ENCODING ? cap_instruction : 32'd0;
  assign exception_id    = cap_id;

endmodule

// File: tb/tb_illegal_instruction_trap_sequencer.sv
// Directed bench: one saturating 4-bit counter instance with tval = encoding, and one
// 32-bit counter instance with tval forced to zero, both driven by the same stimulus.
module tb_illegal_instruction_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        decode_valid;
  logic [31:0] decode_pc;
  logic [31:0] decode_instruction;
  logic [2:0]  decode_id;
  logic        illegal_instruction;
  logic        gc_flush;
  logic        inflight_empty;
  logic        exception_ack;

  logic        issue_block_a, exception_valid_a;
  logic [4:0]  exception_code_a;
  logic [31:0] exception_pc_a, exception_tval_a;
  logic [2:0]  exception_id_a;
  logic [3:0]  illegal_count_a;

  logic        issue_block_b, exception_valid_b;
  logic [4:0]  exception_code_b;
  logic [31:0] exception_pc_b, exception_tval_b;
  logic [2:0]  exception_id_b;
  logic [31:0] illegal_count_b;

  int vectors;
  int miscompares;

  illegal_instruction_trap_sequencer #(
    .ID_W(3), .TVAL_ENCODING(1'b1), .COUNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .decode_valid(decode_valid), .decode_pc(decode_pc),
    .decode_instruction(decode_instruction), .decode_id(decode_id),
    .illegal_instruction(illegal_instruction), .gc_flush(gc_flush),
    .inflight_empty(inflight_empty), .issue_block(issue_block_a),
    .exception_valid(exception_valid_a), .exception_code(exception_code_a),
    .exception_pc(exception_pc_a), .exception_tval(exception_tval_a),
    .exception_id(exception_id_a), .exception_ack(exception_ack),
    .illegal_count(illegal_count_a)
  );

  illegal_instruction_trap_sequencer #(
    .ID_W(3), .TVAL_ENCODING(1'b0), .COUNT_W(32)
  ) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .decode_valid(decode_valid), .decode_pc(decode_pc),
    .decode_instruction(decode_instruction), .decode_id(decode_id),
    .illegal_instruction(illegal_instruction), .gc_flush(gc_flush),
    .inflight_empty(inflight_empty), .issue_block(issue_block_b),
    .exception_valid(exception_valid_b), .exception_code(exception_code_b),
    .exception_pc(exception_pc_b), .exception_tval(exception_tval_b),
    .exception_id(exception_id_b), .exception_ack(exception_ack),
    .illegal_count(illegal_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic dv, input logic ill, input logic [31:0] pc,
                                input logic [31:0] instr, input logic [2:0] id);
    decode_valid        = dv;
    illegal_instruction = ill;
    decode_pc           = pc;
    decode_instruction  = instr;
    decode_id           = id;
  endtask

  // One complete trap with drain already empty and immediate ack.
  task automatic quick_trap(input logic [31:0] pc);
    apply_stimulus(1'b1, 1'b1, pc, 32'h0000_0013, 3'd1);
    inflight_empty = 1'b1;
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    exception_ack = 1'b1;
    tick();
    exception_ack = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n          = 1'b0;
    gc_flush       = 1'b0;
    inflight_empty = 1'b0;
    exception_ack  = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    #2;
    check_output("reset_valid", {31'd0, exception_valid_a}, 32'd0);
    check_output("reset_count", {28'd0, illegal_count_a}, 32'd0);
    check_output("reset_pc", exception_pc_a, 32'd0);
    check_output("reset_code", {27'd0, exception_code_a}, 32'd2);
    check_output("reset_block", {31'd0, issue_block_a}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Minimum-latency trap
    apply_stimulus(1'b1, 1'b1, 32'h8000_0010, 32'h0000_0000, 3'd5);
    inflight_empty = 1'b1;
    #1;
    check_output("t1_block_decode", {31'd0, issue_block_a}, 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    #1;
    check_output("t1_block_drain", {31'd0, issue_block_a}, 32'd1);
    check_output("t1_valid_n1", {31'd0, exception_valid_a}, 32'd0);
    tick();
    check_output("t1_valid_n2", {31'd0, exception_valid_a}, 32'd1);
    check_output("t1_code", {27'd0, exception_code_a}, 32'd2);
    check_output("t1_pc", exception_pc_a, 32'h8000_0010);
    check_output("t1_tval", exception_tval_a, 32'd0);
    check_output("t1_id", {29'd0, exception_id_a}, 32'd5);
    check_output("t1_block_req", {31'd0, issue_block_a}, 32'd1);
    exception_ack = 1'b1;
    tick();
    exception_ack = 1'b0;
    #1;
    check_output("t1_valid_done", {31'd0, exception_valid_a}, 32'd0);
    check_output("t1_block_idle", {31'd0, issue_block_a}, 32'd0);
    check_output("t1_count_a", {28'd0, illegal_count_a}, 32'd1);
    check_output("t1_count_b", illegal_count_b, 32'd1);

    // Long drain
    inflight_empty = 1'b0;
    apply_stimulus(1'b1, 1'b1, 32'h8000_0100, 32'hFFFF_FFFF, 3'd2);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("t2_drain_valid", {31'd0, exception_valid_a}, 32'd0);
      check_output("t2_drain_block", {31'd0, issue_block_a}, 32'd1);
      tick();
    end
    inflight_empty = 1'b1;
    #1;
    check_output("t2_valid_before", {31'd0, exception_valid_a}, 32'd0);
    tick();
    check_output("t2_valid", {31'd0, exception_valid_a}, 32'd1);
    check_output("t2_tval_enc", exception_tval_a, 32'hFFFF_FFFF);
    check_output("t2_tval_zero", exception_tval_b, 32'd0);
    check_output("t2_pc_b", exception_pc_b, 32'h8000_0100);
    exception_ack = 1'b1;
    tick();
    exception_ack = 1'b0;
    check_output("t2_count", {28'd0, illegal_count_a}, 32'd2);

    // Flush during drain wins over inflight_empty
    inflight_empty = 1'b0;
    apply_stimulus(1'b1, 1'b1, 32'h8000_0180, 32'h1234_5678, 3'd3);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    gc_flush       = 1'b1;
    inflight_empty = 1'b1;
    tick();
    gc_flush = 1'b0;
    check_output("t3_flush_valid", {31'd0, exception_valid_a}, 32'd0);
    check_output("t3_flush_block", {31'd0, issue_block_a}, 32'd0);
    tick();
    check_output("t3_flush_valid2", {31'd0, exception_valid_a}, 32'd0);
    check_output("t3_flush_count", {28'd0, illegal_count_a}, 32'd2);

    // Flush at the decode cycle: blocked but never accepted
    apply_stimulus(1'b1, 1'b1, 32'h8000_01C0, 32'h0BAD_0BAD, 3'd4);
    gc_flush = 1'b1;
    #1;
    check_output("t3_decode_flush_block", {31'd0, issue_block_a}, 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    gc_flush = 1'b0;
    #1;
    check_output("t3_no_accept", {31'd0, issue_block_a}, 32'd0);
    tick();
    check_output("t3_no_request", {31'd0, exception_valid_a}, 32'd0);

    // Legal decode instruction has no effect
    apply_stimulus(1'b1, 1'b0, 32'h8000_0400, 32'h0000_0013, 3'd6);
    #1;
    check_output("t3_legal_block", {31'd0, issue_block_a}, 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    #1;
    check_output("t3_legal_idle", {31'd0, issue_block_a}, 32'd0);

    // Request held without ack while gc_flush toggles
    apply_stimulus(1'b1, 1'b1, 32'h8000_0200, 32'h0000_FFFF, 3'd7);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      gc_flush = i[0];
      #1;
      check_output("t4_hold_valid", {31'd0, exception_valid_a}, 32'd1);
      check_output("t4_hold_pc", exception_pc_a, 32'h8000_0200);
      check_output("t4_hold_tval", exception_tval_a, 32'h0000_FFFF);
      check_output("t4_hold_id", {29'd0, exception_id_a}, 32'd7);
      tick();
    end
    gc_flush      = 1'b0;
    exception_ack = 1'b1;
    apply_stimulus(1'b1, 1'b1, 32'h8000_0300, 32'hDEAD_BEEF, 3'd1);
    tick();
    exception_ack = 1'b0;
    check_output("t4_count", {28'd0, illegal_count_a}, 32'd3);
    check_output("t4_no_same_cycle_accept", exception_pc_a, 32'h8000_0200);
    check_output("t4_idle_block", {31'd0, issue_block_a}, 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    check_output("t4_next_accept_pc", exception_pc_a, 32'h8000_0300);
    check_output("t4_count_single", {28'd0, illegal_count_a}, 32'd3);
    tick();
    exception_ack = 1'b1;
    tick();
    exception_ack = 1'b0;
    check_output("t4_count_next", {28'd0, illegal_count_a}, 32'd4);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 13; i++) quick_trap(32'h8000_1000 + 32'(i * 4));
    check_output("t5_sat_a", {28'd0, illegal_count_a}, 32'hF);
    check_output("t5_count_b", illegal_count_b, 32'd17);
    quick_trap(32'h8000_2000);
    check_output("t5_sat_hold_a", {28'd0, illegal_count_a}, 32'hF);
    check_output("t5_count_b2", illegal_count_b, 32'd18);

    // Asynchronous reset mid-request
    apply_stimulus(1'b1, 1'b1, 32'h8000_3000, 32'hCAFE_F00D, 3'd2);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    check_output("t6_pre_valid", {31'd0, exception_valid_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_rst_valid", {31'd0, exception_valid_a}, 32'd0);
    check_output("t6_rst_count_a", {28'd0, illegal_count_a}, 32'd0);
    check_output("t6_rst_count_b", illegal_count_b, 32'd0);
    check_output("t6_rst_pc", exception_pc_a, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    quick_trap(32'h8000_4000);
    check_output("t6_after_count", {28'd0, illegal_count_a}, 32'd1);
    check_output("t6_after_pc", exception_pc_a, 32'h8000_4000);
    check_output("t6_after_valid", {31'd0, exception_valid_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
